fei4_data_tx: RTL and testbench

//  FE-I4 DOB data-output emulator: transmit end of the FE-I4 readout link, counterpart of the FPGA's fei4_rx.

---
 rtl/fei4_tx_pkg.sv | 17 +
 rtl/enc_8b10b.sv | 61 ++++++
 rtl/fei4_data_tx.sv | 130 +++++++++++++
 tb/tb_fei4_data_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fei4_tx_pkg.sv
// Shared constants and types for the FE-I4 data-output transmitter.
package fei4_tx_pkg;

   localparam logic [7:0] K28_1 = 8'h3C;   // idle
   localparam logic [7:0] K28_5 = 8'hBC;   // end of frame
   localparam logic [7:0] K28_7 = 8'hFC;   // start of frame

   typedef enum logic [2:0] {IDLE, SOF, D0, D1, D2, EOF} state_t;

   function automatic logic [2:0] ones6(input logic [5:0] v);
      logic [2:0] n;
      n = 3'd0;
      for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
      return n;
   endfunction

endpackage

// File: rtl/enc_8b10b.sv
// Combinational 8b10b encoder, code[9] is bit 'a'; zero latency, no flow control.
// Only the K28.y control group is needed on this link, so k forces the K28 6b sub-block.
module enc_8b10b
   import fei4_tx_pkg::*;
(
   input  logic       k,
   input  logic [7:0] data,
   input  logic       rd_in,
   output logic [9:0] code,
   output logic       rd_out
);
   logic [4:0] x;
   logic [2:0] y;
   logic [5:0] c6;
   logic [3:0] c4;
   logic       bal6, bal4, flip6, flip4, rd6, a7;

   assign x = data[4:0];
   assign y = data[7:5];

   always_comb begin
      c6 = 6'b000000;
      case (x)
         5'd0:  c6 = 6'b100111;  5'd1:  c6 = 6'b011101;  5'd2:  c6 = 6'b101101;  5'd3:  c6 = 6'b110001;
         5'd4:  c6 = 6'b110101;  5'd5:  c6 = 6'b101001;  5'd6:  c6 = 6'b011001;  5'd7:  c6 = 6'b111000;
         5'd8:  c6 = 6'b111001;  5'd9:  c6 = 6'b100101;  5'd10: c6 = 6'b010101;  5'd11: c6 = 6'b110100;
         5'd12: c6 = 6'b001101;  5'd13: c6 = 6'b101100;  5'd14: c6 = 6'b011100;  5'd15: c6 = 6'b010111;
         5'd16: c6 = 6'b011011;  5'd17: c6 = 6'b100011;  5'd18: c6 = 6'b010011;  5'd19: c6 = 6'b110010;
         5'd20: c6 = 6'b001011;  5'd21: c6 = 6'b101010;  5'd22: c6 = 6'b011010;  5'd23: c6 = 6'b111010;
         5'd24: c6 = 6'b110011;  5'd25: c6 = 6'b100110;  5'd26: c6 = 6'b010110;  5'd27: c6 = 6'b110110;
         5'd28: c6 = 6'b001110;  5'd29: c6 = 6'b101110;  5'd30: c6 = 6'b011110;  5'd31: c6 = 6'b101011;
         default: c6 = 6'b000000;
      endcase
      if (k) c6 = 6'b001111;
      bal6  = (ones6(c6) == 3'd3);
      // D.7 is balanced but still alternates with disparity
      flip6 = rd_in && (!bal6 || (!k && x == 5'd7));
      rd6   = bal6 ? rd_in : ~rd_in;

      // Alternate D.x.7 avoids a run of five identical bits across the sub-block boundary
      a7 = !k && (rd6 ? (x == 5'd11 || x == 5'd13 || x == 5'd14)
                      : (x == 5'd17 || x == 5'd18 || x == 5'd20));
      c4 = 4'b0000;
      case (y)
         3'd0: c4 = 4'b1011;
         3'd1: c4 = k ? 4'b0110 : 4'b1001;
         3'd2: c4 = k ? 4'b1010 : 4'b0101;
         3'd3: c4 = 4'b1100;
         3'd4: c4 = 4'b1101;
         3'd5: c4 = k ? 4'b0101 : 4'b1010;
         3'd6: c4 = k ? 4'b1001 : 4'b0110;
         3'd7: c4 = (k || a7) ? 4'b0111 : 4'b1110;
         default: c4 = 4'b0000;
      endcase
      bal4   = (ones6({2'b00, c4}) == 3'd2);
      flip4  = rd6 && (k || !bal4 || y == 3'd3);
      code   = {(flip6 ? ~c6 : c6), (flip4 ? ~c4 : c4)};
      rd_out = bal4 ? rd6 : ~rd6;
   end

endmodule

// File: rtl/fei4_data_tx.sv
// FE-I4 DOB transmitter: 24-bit records in, 8b10b frames out serially at one bit per CLK.
// REC_READY pulses once per accepted record; that record's first byte reaches DOUT the next cycle.
module fei4_data_tx
   import fei4_tx_pkg::*;
#(
   parameter int IDLE_MIN = 1,
   parameter int CNT_W    = 16
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENABLE,
   input  logic [23:0]      REC_DATA,
   input  logic             REC_VALID,
   input  logic             REC_LAST,
   output logic             REC_READY,
   output logic             DOUT,
   output logic             FRAME_ACTIVE,
   output logic [CNT_W-1:0] FRAME_CNT,
   output logic             UNDERRUN
);
   localparam int                IDLE_W   = $clog2(IDLE_MIN + 1);
   localparam logic [IDLE_W-1:0] IDLE_SAT = IDLE_W'(IDLE_MIN);

   state_t            state, state_nxt;
   logic [3:0]        bit_cnt;
   logic              primed, decide;
   logic [9:0]        sr, code;
   logic              rd, rd_nxt;
   logic [15:0]       hold_dat;
   logic              hold_last;
   logic [IDLE_W-1:0] idle_cnt;
   logic              sym_k, take_rec;
   logic [7:0]        sym_dat;

   // Nothing is in flight straight after reset, so the first clock is itself a decision point.
   assign decide = !primed || (bit_cnt == 4'd9);

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (decide) begin
         case (state)
            IDLE:    if (idle_cnt == IDLE_SAT && ENABLE && REC_VALID) state_nxt = SOF;
            SOF:     state_nxt = D0;
            D0:      state_nxt = D1;
            D1:      state_nxt = D2;
            D2:      state_nxt = (hold_last || !REC_VALID) ? EOF : D0;
            EOF:     state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      sym_k    = 1'b1;
      sym_dat  = K28_1;
      take_rec = 1'b0;
      case (state_nxt)
         SOF: sym_dat = K28_7;
         D0: begin
            sym_k    = 1'b0;
            sym_dat  = REC_DATA[23:16];
            take_rec = decide;
         end
         D1: begin
            sym_k   = 1'b0;
            sym_dat = hold_dat[15:8];
         end
         D2: begin
            sym_k   = 1'b0;
            sym_dat = hold_dat[7:0];
         end
         EOF:     sym_dat = K28_5;
         default: sym_dat = K28_1;
      endcase
   end

   assign REC_READY = take_rec && !RST;
   assign DOUT      = sr[9];

   enc_8b10b u_enc (
      .k      (sym_k),
      .data   (sym_dat),
      .rd_in  (rd),
      .code   (code),
      .rd_out (rd_nxt)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         primed       <= 1'b0;
         bit_cnt      <= 4'd0;
         sr           <= 10'd0;
         rd           <= 1'b0;
         hold_dat     <= 16'd0;
         hold_last    <= 1'b0;
         idle_cnt     <= '0;
         FRAME_ACTIVE <= 1'b0;
         FRAME_CNT    <= '0;
         UNDERRUN     <= 1'b0;
      end else begin
         primed <= 1'b1;
         if (decide) begin
            sr      <= code;
            rd      <= rd_nxt;
            bit_cnt <= 4'd0;
            if (state_nxt == D0 && state != D0) begin
               hold_dat  <= REC_DATA[15:0];
               hold_last <= REC_LAST;
            end
            if (state_nxt == SOF) FRAME_ACTIVE <= 1'b1;
            if (state_nxt == EOF && state != EOF) begin
               FRAME_ACTIVE <= 1'b0;
               FRAME_CNT    <= FRAME_CNT + CNT_W'(1);
               idle_cnt     <= '0;
            end
            if (state == D2 && !hold_last && !REC_VALID) UNDERRUN <= 1'b1;
            if (state_nxt == IDLE && idle_cnt != IDLE_SAT) idle_cnt <= idle_cnt + IDLE_W'(1);
         end else begin
            sr      <= {sr[8:0], 1'b0};
            bit_cnt <= bit_cnt + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_fei4_data_tx.sv
// Bench for fei4_data_tx: deserialises DOUT, checks every symbol against an expected frame queue.
module tb_fei4_data_tx;
   localparam int IDLE_MIN = 1;

   logic        clk = 1'b0;
   logic        rst, enable, rec_valid, rec_last;
   logic [23:0] rec_data;
   logic        rec_ready, dout, frame_active, underrun;
   logic [15:0] frame_cnt;

   int nchk = 0, nerr = 0, cyc = 0;

   fei4_data_tx #(.IDLE_MIN(IDLE_MIN), .CNT_W(16)) dut (
      .CLK(clk), .RST(rst), .ENABLE(enable), .REC_DATA(rec_data), .REC_VALID(rec_valid),
      .REC_LAST(rec_last), .REC_READY(rec_ready), .DOUT(dout), .FRAME_ACTIVE(frame_active),
      .FRAME_CNT(frame_cnt), .UNDERRUN(underrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // RD- forms of the 5b/6b and 3b/4b sub-blocks, bit 'a' / 'f' leftmost
   logic [5:0] t6 [0:31] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                             6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                             6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                             6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                             6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                             6'b011110, 6'b101011};
   logic [3:0] d4 [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
   logic [3:0] k4 [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};

   function automatic int ones(input logic [9:0] v);
      int n = 0;
      for (int i = 0; i < 10; i++) n += int'(v[i]);
      return n;
   endfunction

   function automatic logic [9:0] tb_enc(input bit k, input logic [7:0] b, input bit rd);
      logic [5:0] c6;
      logic [3:0] c4;
      bit r;
      int x, y;
      x  = int'(b[4:0]);
      y  = int'(b[7:5]);
      c6 = k ? 6'b001111 : t6[x];
      r  = (ones({4'b0, c6}) == 3) ? rd : !rd;
      if (rd && (ones({4'b0, c6}) != 3 || c6 == 6'b111000)) c6 = ~c6;
      c4 = k ? k4[y] : d4[y];
      if (!k && y == 7 && ((!r && (x == 17 || x == 18 || x == 20)) || (r && (x == 11 || x == 13 || x == 14))))
         c4 = 4'b0111;
      if (r && (k || ones({6'b0, c4}) != 2 || c4 == 4'b1100)) c4 = ~c4;
      return {c6, c4};
   endfunction

   // Expected non-idle symbols: {first byte of a record, k, byte}
   logic [9:0] expq [$];
   logic       rst_s = 1'b1;
   int         bitpos = 0, idles = 0, n_ready = 0, frames_seen = 0, nsym = 0;
   bit         m_rd = 1'b0, in_frame = 1'b0, ready_mark = 1'b0, rdy0 = 1'b0, fa0 = 1'b0;
   logic [9:0] shreg = '0;
   logic [9:0] first_code [0:1] = '{10'd0, 10'd0};

   always @(posedge clk) rst_s <= rst;

   always @(negedge clk) begin
      if (rst_s) begin
         chk("dout_in_reset", {31'd0, dout}, 32'd0);
         chk("ready_in_reset", {31'd0, rec_ready}, 32'd0);
         bitpos = 0; m_rd = 1'b0; in_frame = 1'b0; idles = 0; nsym = 0; ready_mark = 1'b0;
         expq.delete();
      end else begin
         shreg = {shreg[8:0], dout};
         if (bitpos == 0) begin
            fa0 = frame_active;
            rdy0 = ready_mark;
            ready_mark = 1'b0;
         end
         if (rec_ready) begin
            chk("ready_phase", bitpos, 9);
            ready_mark = 1'b1;
            n_ready++;
         end
         bitpos++;
         if (bitpos == 10) begin
            bitpos = 0;
            if (nsym < 2) first_code[nsym] = shreg;
            nsym++;
            if (shreg == tb_enc(1'b1, 8'h3C, m_rd)) begin
               chk("idle_in_frame", {31'd0, in_frame}, 32'd0);
               chk("idle_active", {31'd0, fa0}, 32'd0);
               chk("idle_after_ready", {31'd0, rdy0}, 32'd0);
               idles++;
            end else if (expq.size() == 0) begin
               chk("unexpected_symbol", {22'd0, shreg}, {22'd0, tb_enc(1'b1, 8'h3C, m_rd)});
            end else begin
               logic [9:0] e;
               e = expq.pop_front();
               chk("symbol", {22'd0, shreg}, {22'd0, tb_enc(e[8], e[7:0], m_rd)});
               chk("frame_active", {31'd0, fa0}, {31'd0, (e[8:0] != {1'b1, 8'hBC})});
               chk("ready_to_byte0", {31'd0, rdy0}, {31'd0, e[9]});
               if (e[8:0] == {1'b1, 8'hFC}) begin
                  chk("idle_gap", {31'd0, (idles >= IDLE_MIN)}, 32'd1);
                  in_frame = 1'b1;
               end
               if (e[8:0] == {1'b1, 8'hBC}) begin
                  in_frame = 1'b0;
                  idles = 0;
                  frames_seen++;
               end
            end
            if (ones(shreg) > 5) m_rd = 1'b1;
            else if (ones(shreg) < 5) m_rd = 1'b0;
         end
      end
   end

   task automatic push(input bit first, input bit k, input logic [7:0] b);
      expq.push_back({first, k, b});
   endtask

   task automatic push_frame(input logic [23:0] recs [$]);
      push(1'b0, 1'b1, 8'hFC);
      foreach (recs[i]) begin
         push(1'b1, 1'b0, recs[i][23:16]);
         push(1'b0, 1'b0, recs[i][15:8]);
         push(1'b0, 1'b0, recs[i][7:0]);
      end
      push(1'b0, 1'b1, 8'hBC);
   endtask

   task automatic put_rec(input logic [23:0] d, input logic last, output int t);
      bit got = 1'b0;
      rec_data = d; rec_last = last; rec_valid = 1'b1; t = -1;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (rec_ready) begin got = 1'b1; t = cyc; end
      end
      chk("record_accepted", {31'd0, got}, 32'd1);
      @(posedge clk); #1;
      rec_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge clk);
         if (expq.size() == 0 && !in_frame) ok = 1'b1;
      end
      chk("frame_done", {31'd0, ok}, 32'd1);
      repeat (25) @(posedge clk);
      #1;
   endtask

   initial begin
      int t0, t1, base, fseen;
      logic [23:0] recs [$];
      rst = 1'b1; enable = 1'b1; rec_valid = 1'b0; rec_last = 1'b0; rec_data = '0;

      // Pin the bench encoder to hand-derived codes
      chk("enc_k28_1_neg", {22'd0, tb_enc(1'b1, 8'h3C, 1'b0)}, 32'b0011111001);
      chk("enc_k28_7_neg", {22'd0, tb_enc(1'b1, 8'hFC, 1'b0)}, 32'b0011111000);
      chk("enc_d9_7_neg",  {22'd0, tb_enc(1'b0, 8'hE9, 1'b0)}, 32'b1001011110);

      repeat (3) @(posedge clk); #1 rst = 1'b0;

      // 1: idle stream after reset
      repeat (60) @(posedge clk); #1;
      chk("t1_code0", {22'd0, first_code[0]}, 32'b0011111001);
      chk("t1_code1", {22'd0, first_code[1]}, 32'b1100000110);
      chk("t1_no_ready", n_ready, 0);
      chk("t1_cnt", {16'd0, frame_cnt}, 32'd0);
      chk("t1_active", {31'd0, frame_active}, 32'd0);
      chk("t1_underrun", {31'd0, underrun}, 32'd0);

      // 2: single record frame
      base = n_ready;
      recs = '{24'hE91234};
      push_frame(recs);
      put_rec(24'hE91234, 1'b1, t0);
      wait_done();
      chk("t2_pulses", n_ready - base, 1);
      chk("t2_cnt", {16'd0, frame_cnt}, 32'd1);
      chk("t2_underrun", {31'd0, underrun}, 32'd0);

      // 3: back-to-back records in one frame
      recs = '{24'h000001, 24'h000002};
      push_frame(recs);
      put_rec(24'h000001, 1'b0, t0);
      put_rec(24'h000002, 1'b1, t1);
      wait_done();
      chk("t3_spacing", t1 - t0, 30);
      chk("t3_cnt", {16'd0, frame_cnt}, 32'd2);

      // 4: source runs dry mid-frame
      recs = '{24'hABCDEF};
      push_frame(recs);
      put_rec(24'hABCDEF, 1'b0, t0);
      wait_done();
      chk("t4_underrun", {31'd0, underrun}, 32'd1);
      chk("t4_cnt", {16'd0, frame_cnt}, 32'd3);
      repeat (50) @(posedge clk); #1;
      chk("t4_sticky", {31'd0, underrun}, 32'd1);

      // 5: reset during bit 4 of byte CD
      fseen = frames_seen;
      recs = '{24'hABCDEF};
      push_frame(recs);
      put_rec(24'hABCDEF, 1'b1, t0);
      repeat (14) @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("t5_dout_rst", {31'd0, dout}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      chk("t5_cnt_clr", {16'd0, frame_cnt}, 32'd0);
      chk("t5_underrun_clr", {31'd0, underrun}, 32'd0);
      repeat (40) @(posedge clk); #1;
      chk("t5_code0", {22'd0, first_code[0]}, 32'b0011111001);
      chk("t5_no_eof", frames_seen, fseen);
      chk("t5_active", {31'd0, frame_active}, 32'd0);

      // 6: ENABLE gates frame start only
      base = n_ready;
      enable = 1'b0; rec_data = 24'h123456; rec_last = 1'b0; rec_valid = 1'b1;
      repeat (100) @(posedge clk); #1;
      chk("t6_held_off", n_ready - base, 0);
      chk("t6_inactive", {31'd0, frame_active}, 32'd0);
      recs = '{24'h123456, 24'h789ABC};
      push_frame(recs);
      enable = 1'b1;
      put_rec(24'h123456, 1'b0, t0);
      enable = 1'b0;
      put_rec(24'h789ABC, 1'b1, t1);
      wait_done();
      chk("t6_cnt", {16'd0, frame_cnt}, 32'd1);
      chk("t6_underrun", {31'd0, underrun}, 32'd0);
      chk("t6_spacing", t1 - t0, 30);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
